// File: rtl/window_3x3_gen_pkg.sv
// window_3x3_gen_pkg: shared pixel type and size constants for the median-filter path
package window_3x3_gen_pkg;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int IMG_WIDTH_DEF = 640;
    localparam int IMG_HEIGHT_DEF = 480;
    localparam int COL_W = $clog2(IMG_WIDTH_DEF);
    localparam int ROW_W = $clog2(IMG_HEIGHT_DEF);
    typedef logic [DATA_WIDTH_DEF-1:0] pixel_t;
endpackage

// File: rtl/window_3x3_gen_line_buffer.sv
// window_3x3_gen_line_buffer: one image line of storage, combinational read, synchronous write
// ports: clk; en writes wdata at addr; rdata is the current (pre-write) content at addr
module window_3x3_gen_line_buffer
    import window_3x3_gen_pkg::*;
#(
    parameter int DEPTH = IMG_WIDTH_DEF,
    parameter int WIDTH = DATA_WIDTH_DEF,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             en,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];
    assign rdata = mem[addr];
    always_ff @(posedge clk)
        if (en) mem[addr] <= wdata;
endmodule

// File: rtl/window_3x3_gen.sv
// window_3x3_gen: streaming 3x3 window generator feeding the median sorting stages
// ports: clk, rst_n (async, active-low); frame_start, data_in_valid, data_in (raster pixels in);
//        data_out_valid, win_r*c* (registered window, r2 = newest line), frame_done (last window)
module window_3x3_gen
    import window_3x3_gen_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int IMG_WIDTH = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT = IMG_HEIGHT_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_start,
    input  logic                  data_in_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  data_out_valid,
    output logic [DATA_WIDTH-1:0] win_r0c0,
    output logic [DATA_WIDTH-1:0] win_r0c1,
    output logic [DATA_WIDTH-1:0] win_r0c2,
    output logic [DATA_WIDTH-1:0] win_r1c0,
    output logic [DATA_WIDTH-1:0] win_r1c1,
    output logic [DATA_WIDTH-1:0] win_r1c2,
    output logic [DATA_WIDTH-1:0] win_r2c0,
    output logic [DATA_WIDTH-1:0] win_r2c1,
    output logic [DATA_WIDTH-1:0] win_r2c2,
    output logic                  frame_done
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    logic [CW-1:0] col, cur_col;
    logic [RW-1:0] row, cur_row;
    logic [DATA_WIDTH-1:0] lb1_q, lb2_q;
    logic last_col, last_row, interior;
    // frame_start overrides the counters combinationally so a coincident pixel lands at (0,0)
    always_comb begin
        cur_col = frame_start ? '0 : col;
        cur_row = frame_start ? '0 : row;
        last_col = cur_col == CW'(IMG_WIDTH - 1);
        last_row = cur_row == RW'(IMG_HEIGHT - 1);
        interior = cur_col >= CW'(2) && cur_row >= RW'(2);
    end
    // lb1 holds the previous line, lb2 the one before; lb2 is refilled from lb1's old value
    window_3x3_gen_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(DATA_WIDTH), .AW(CW)) u_lb1 (
        .clk(clk), .en(data_in_valid), .addr(cur_col), .wdata(data_in), .rdata(lb1_q)
    );
    window_3x3_gen_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(DATA_WIDTH), .AW(CW)) u_lb2 (
        .clk(clk), .en(data_in_valid), .addr(cur_col), .wdata(lb1_q), .rdata(lb2_q)
    );
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            col <= '0;
            row <= '0;
            data_out_valid <= 1'b0;
            frame_done <= 1'b0;
            win_r0c0 <= '0;
            win_r0c1 <= '0;
            win_r0c2 <= '0;
            win_r1c0 <= '0;
            win_r1c1 <= '0;
            win_r1c2 <= '0;
            win_r2c0 <= '0;
            win_r2c1 <= '0;
            win_r2c2 <= '0;
        end else begin
            data_out_valid <= data_in_valid && interior;
            frame_done <= data_in_valid && last_col && last_row;
            col <= !data_in_valid ? cur_col : last_col ? '0 : cur_col + 1'b1;
            row <= !data_in_valid || !last_col ? cur_row : last_row ? '0 : cur_row + 1'b1;
            if (data_in_valid) begin
                win_r0c0 <= win_r0c1;
                win_r0c1 <= win_r0c2;
                win_r0c2 <= lb2_q;
                win_r1c0 <= win_r1c1;
                win_r1c1 <= win_r1c2;
                win_r1c2 <= lb1_q;
                win_r2c0 <= win_r2c1;
                win_r2c1 <= win_r2c2;
                win_r2c2 <= data_in;
            end
        end
endmodule

// File: tb/tb_window_3x3_gen.sv
// tb_window_3x3_gen: directed checks of window_3x3_gen on a 5x4 image
module tb_window_3x3_gen;
    localparam int W = 5;
    localparam int H = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic frame_start = 1'b0;
    logic data_in_valid = 1'b0;
    logic [7:0] data_in = '0;
    logic data_out_valid, frame_done;
    logic [7:0] w00, w01, w02, w10, w11, w12, w20, w21, w22;
    logic [71:0] win;
    logic acc_q = 1'b0;
    int n_assert = 0;
    int n_fail = 0;
    int viol = 0;
    typedef struct {logic [71:0] w; logic fd;} win_t;
    win_t q[$];

    window_3x3_gen #(.DATA_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .data_in_valid(data_in_valid),
        .data_in(data_in), .data_out_valid(data_out_valid),
        .win_r0c0(w00), .win_r0c1(w01), .win_r0c2(w02),
        .win_r1c0(w10), .win_r1c1(w11), .win_r1c2(w12),
        .win_r2c0(w20), .win_r2c1(w21), .win_r2c2(w22),
        .frame_done(frame_done)
    );

    assign win = {w00, w01, w02, w10, w11, w12, w20, w21, w22};
    always #5 clk = ~clk;
    always @(posedge clk) acc_q <= data_in_valid;

    // capture every emitted window; a window without an accepted input, or a stray frame_done, is a violation
    always @(negedge clk) begin
        if (data_out_valid) begin
            q.push_back('{win, frame_done});
            if (!acc_q) viol++;
        end
        if (frame_done && !data_out_valid) viol++;
    end

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] exp_win(input logic [7:0] b, input logic [7:0] m, input int r, input int c);
        logic [71:0] v = '0;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
                v = {v[63:0], 8'(int'(b) + int'(m) * ((r + dr) * 16 + c + dc))};
        return v;
    endfunction

    task automatic frame(input logic [7:0] b, input logic [7:0] m, input bit gap, input bit fs, input int npix);
        for (int i = 0; i < npix; i++) begin
            @(negedge clk);
            frame_start = fs && i == 0;
            data_in_valid = 1'b1;
            data_in = 8'(int'(b) + int'(m) * ((i / W) * 16 + i % W));
            if (gap) begin
                @(negedge clk);
                frame_start = 1'b0;
                data_in_valid = 1'b0;
                if (i % 4 == 2) repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            frame_start = 1'b0;
            data_in_valid = 1'b0;
        end
    endtask

    task automatic chk_frame(input string tag, input logic [7:0] b, input logic [7:0] m, input int off);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("%s_win%0d", tag, i), q[off + i].w, exp_win(b, m, 1 + i / 3, 1 + i % 3));
            chk($sformatf("%s_fd%0d", tag, i), 72'(q[off + i].fd), 72'(i == 5));
        end
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", 72'(data_out_valid), 72'(0));
        chk("rst_win", win, 72'h0);
        chk("rst_fd", 72'(frame_done), 72'(0));
        @(negedge clk);
        rst_n = 1'b1;

        frame(8'h00, 8'h01, 1'b0, 1'b0, W * H);
        idle(2);
        chk("s1_count", 72'(q.size()), 72'(6));
        chk("s1_first", q[0].w, 72'h000102_101112_202122);
        chk("s1_last", q[5].w, 72'h121314_222324_323334);
        chk_frame("s1", 8'h00, 8'h01, 0);
        q.delete();

        frame(8'h00, 8'h01, 1'b1, 1'b0, W * H);
        idle(2);
        chk("s2_count", 72'(q.size()), 72'(6));
        chk_frame("s2", 8'h00, 8'h01, 0);
        q.delete();

        frame(8'h00, 8'h01, 1'b0, 1'b1, W * H);
        frame(8'h80, 8'h01, 1'b0, 1'b1, W * H);
        idle(2);
        chk("s3_count", 72'(q.size()), 72'(12));
        chk("s3_first2", q[6].w, 72'h808182_909192_a0a1a2);
        chk_frame("s3a", 8'h00, 8'h01, 0);
        chk_frame("s3b", 8'h80, 8'h01, 6);
        q.delete();

        frame(8'h00, 8'h01, 1'b0, 1'b1, 14);
        @(negedge clk);
        frame_start = 1'b1;
        data_in_valid = 1'b0;
        frame(8'h00, 8'h01, 1'b0, 1'b0, W * H);
        idle(2);
        chk("s4_count", 72'(q.size()), 72'(8));
        chk("s4_abort_win0", q[0].w, 72'h000102_101112_202122);
        chk("s4_abort_win1", q[1].w, 72'h010203_111213_212223);
        chk("s4_abort_fd0", 72'(q[0].fd), 72'(0));
        chk("s4_abort_fd1", 72'(q[1].fd), 72'(0));
        chk_frame("s4", 8'h00, 8'h01, 2);
        q.delete();

        frame(8'h00, 8'h01, 1'b0, 1'b1, 13);
        @(posedge clk);
        #2;
        chk("s5_pre_valid", 72'(data_out_valid), 72'(1));
        rst_n = 1'b0;
        data_in_valid = 1'b0;
        #1;
        chk("s5_rst_valid", 72'(data_out_valid), 72'(0));
        chk("s5_rst_win", win, 72'h0);
        chk("s5_rst_fd", 72'(frame_done), 72'(0));
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        frame(8'h00, 8'h01, 1'b0, 1'b0, W * H);
        idle(2);
        chk("s5_count", 72'(q.size()), 72'(6));
        chk_frame("s5", 8'h00, 8'h01, 0);
        q.delete();

        frame(8'hff, 8'h00, 1'b0, 1'b1, W * H);
        frame(8'h00, 8'h00, 1'b0, 1'b1, W * H);
        idle(2);
        chk("s6_count", 72'(q.size()), 72'(12));
        chk_frame("s6a", 8'hff, 8'h00, 0);
        chk_frame("s6b", 8'h00, 8'h00, 6);
        q.delete();

        chk("valid_without_input", 72'(viol), 72'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
